// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures architectural register writes from MEM/WB
// into a small FIFO with cycle stamps, drained by a debug consumer.
module wb_trace_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned STAMP_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_wreg,
    input  logic                         wb_m2reg,
    input  logic [31:0]                  wb_alu_result,
    input  logic [31:0]                  wb_mem_data,
    input  logic [4:0]                   wb_write_reg_num,
    input  logic                         trace_en,
    input  logic                         clear_ovf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0]                   out_reg_num,
    output logic [31:0]                  out_data,
    output logic [STAMP_W-1:0]           out_stamp,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [4:0]         reg_num;
        logic [31:0]        data;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [STAMP_W-1:0]   stamp;

    logic cap_c;
    logic pop_c;
    logic full_c;
    logic push_c;
    logic drop_c;
    entry_t cap_entry_c;

    // Capture qualification mirrors the register-file write port
    always_comb begin
        cap_c  = trace_en & wb_wreg & (wb_write_reg_num != 5'd0);
        pop_c  = out_valid & out_ready;
        full_c = (level == LW'(DEPTH));
        push_c = cap_c & (~full_c | pop_c);
        drop_c = cap_c & full_c & ~pop_c;
        cap_entry_c.reg_num = wb_write_reg_num;
        cap_entry_c.data    = wb_m2reg ? wb_mem_data : wb_alu_result;
        cap_entry_c.stamp   = stamp;
    end

    // Storage needs no reset; entries are qualified by level
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wr_ptr] <= cap_entry_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            stamp      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_c && !pop_c) begin
                level <= level + LW'(1);
            end else if (pop_c && !push_c) begin
                level <= level - LW'(1);
            end
            // A drop in the same cycle as a clear leaves a single counted drop
            if (drop_c) begin
                overflow <= 1'b1;
                if (clear_ovf) begin
                    drop_count <= 8'd1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= 8'd0;
            end
        end
    end

    // First-word-fall-through head from registered state only
    always_comb begin
        out_valid   = (level != LW'(0));
        out_reg_num = mem[rd_ptr].reg_num;
        out_data    = mem[rd_ptr].data;
        out_stamp   = mem[rd_ptr].stamp;
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: capture, filtering, ordering, drop,
// saturation/clear, pointer wrap and mid-operation reset.
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned STAMP_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_wreg = 1'b0;
    logic        wb_m2reg = 1'b0;
    logic [31:0] wb_alu_result = '0;
    logic [31:0] wb_mem_data = '0;
    logic [4:0]  wb_write_reg_num = '0;
    logic        trace_en = 1'b1;
    logic        clear_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_reg_num;
    logic [31:0] out_data;
    logic [15:0] out_stamp;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int          total = 0;
    int          bad = 0;
    logic [15:0] stamp_m = '0;
    logic [15:0] s0;

    wb_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk(clk), .rst(rst),
        .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_write_reg_num(wb_write_reg_num),
        .trace_en(trace_en), .clear_ovf(clear_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_num(out_reg_num), .out_data(out_data), .out_stamp(out_stamp),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the stamp model follows the reset seen at that edge
    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) stamp_m = '0;
        else   stamp_m = stamp_m + 16'd1;
    endtask

    task automatic set_cap(input logic we, input logic m2, input logic [31:0] alu,
                           input logic [31:0] md, input logic [4:0] rn);
        wb_wreg = we; wb_m2reg = m2; wb_alu_result = alu;
        wb_mem_data = md; wb_write_reg_num = rn;
    endtask

    task automatic idle();
        set_cap(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        // Reset, then single capture at stamp 5
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        repeat (5) step();
        set_cap(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd8);
        step();
        idle();
        chk("cap1_valid", 64'(out_valid), 64'd1);
        chk("cap1_reg", 64'(out_reg_num), 64'd8);
        chk("cap1_data", 64'(out_data), 64'h1234);
        chk("cap1_stamp", 64'(out_stamp), 64'd5);
        chk("cap1_level", 64'(level), 64'd1);
        step();
        chk("cap1_hold", 64'(out_data), 64'h1234);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("cap1_pop_level", 64'(level), 64'd0);
        chk("cap1_pop_valid", 64'(out_valid), 64'd0);

        // Filtering: r0 write, no wreg, trace disabled
        set_cap(1'b1, 1'b0, 32'h11, 32'h0, 5'd0);
        step();
        chk("filt_r0_level", 64'(level), 64'd0);
        chk("filt_r0_valid", 64'(out_valid), 64'd0);
        set_cap(1'b0, 1'b0, 32'h22, 32'h0, 5'd3);
        step();
        chk("filt_nowreg_level", 64'(level), 64'd0);
        chk("filt_nowreg_valid", 64'(out_valid), 64'd0);
        trace_en = 1'b0;
        set_cap(1'b1, 1'b0, 32'h33, 32'h0, 5'd4);
        step();
        chk("filt_dis_level", 64'(level), 64'd0);
        chk("filt_dis_valid", 64'(out_valid), 64'd0);
        trace_en = 1'b1;
        idle();

        // m2reg select and ordering
        s0 = stamp_m;
        set_cap(1'b1, 1'b1, 32'h5555, 32'hDEAD_BEEF, 5'd1); step();
        set_cap(1'b1, 1'b0, 32'd7, 32'hAAAA, 5'd2);         step();
        set_cap(1'b1, 1'b1, 32'h6666, 32'h0, 5'd3);         step();
        idle();
        chk("ord_level", 64'(level), 64'd3);
        out_ready = 1'b1;
        chk("ord0_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("ord0_reg", 64'(out_reg_num), 64'd1);
        chk("ord0_stamp", 64'(out_stamp), 64'(s0));
        step();
        chk("ord1_data", 64'(out_data), 64'd7);
        chk("ord1_reg", 64'(out_reg_num), 64'd2);
        chk("ord1_stamp", 64'(out_stamp), 64'(s0 + 16'd1));
        step();
        chk("ord2_data", 64'(out_data), 64'd0);
        chk("ord2_reg", 64'(out_reg_num), 64'd3);
        chk("ord2_stamp", 64'(out_stamp), 64'(s0 + 16'd2));
        step();
        out_ready = 1'b0;
        chk("ord_level_end", 64'(level), 64'd0);

        // Fill, drop the 9th, accept the 10th with a simultaneous pop
        for (int i = 0; i < 8; i++) begin
            set_cap(1'b1, 1'b0, 32'(100 + i), 32'h0, 5'(i + 1));
            step();
        end
        idle();
        chk("full_level", 64'(level), 64'd8);
        set_cap(1'b1, 1'b0, 32'd999, 32'h0, 5'd9);
        step();
        idle();
        chk("drop_level", 64'(level), 64'd8);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_cnt", 64'(drop_count), 64'd1);
        chk("drop_head", 64'(out_data), 64'd100);
        set_cap(1'b1, 1'b0, 32'd1000, 32'h0, 5'd10);
        out_ready = 1'b1;
        step();
        idle();
        out_ready = 1'b0;
        chk("simul_level", 64'(level), 64'd8);
        chk("simul_head", 64'(out_data), 64'd101);
        chk("simul_cnt", 64'(drop_count), 64'd1);

        // Saturation and clear
        set_cap(1'b1, 1'b0, 32'hBAD, 32'h0, 5'd11);
        repeat (300) step();
        idle();
        chk("sat_cnt", 64'(drop_count), 64'd255);
        chk("sat_ovf", 64'(overflow), 64'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_cnt", 64'(drop_count), 64'd0);
        set_cap(1'b1, 1'b0, 32'hBAD, 32'h0, 5'd11);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        idle();
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        chk("clrdrop_cnt", 64'(drop_count), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("drain_data", 64'(out_data), 64'(101 + i));
            chk("drain_reg", 64'(out_reg_num), 64'(i + 2));
            step();
        end
        chk("drain_last_data", 64'(out_data), 64'd1000);
        chk("drain_last_reg", 64'(out_reg_num), 64'd10);
        step();
        out_ready = 1'b0;
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Streaming capture+pop across pointer wraps
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) chk("wrap_data", 64'(out_data), 64'(32'h500 + k - 1));
            set_cap(1'b1, 1'b0, 32'(32'h500 + k), 32'h0, 5'((k % 31) + 1));
            step();
            chk("wrap_level", 64'(level), 64'd1);
        end
        idle();
        chk("wrap_tail", 64'(out_data), 64'h513);
        step();
        out_ready = 1'b0;
        chk("wrap_empty", 64'(level), 64'd0);

        // Mid-operation reset with a capture in the reset cycle
        for (int i = 0; i < 3; i++) begin
            set_cap(1'b1, 1'b0, 32'(i), 32'h0, 5'd5);
            step();
        end
        chk("prerst_level", 64'(level), 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        set_cap(1'b1, 1'b0, 32'hCAFE, 32'h0, 5'd6);
        step();
        idle();
        chk("midrst_level1", 64'(level), 64'd1);
        chk("midrst_stamp", 64'(out_stamp), 64'd0);
        chk("midrst_data", 64'(out_data), 64'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
